// File: rtl/check_session_arbiter.sv
// check_session_arbiter: round-robin owner of one shared begin/end nesting checker,
// streaming one whole message per grant and reporting the sampled verdict to its owner.
module check_session_arbiter #(
    parameter int MAX_LEN = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic       o_chk_rst,
    output logic       o_chk_en,
    output logic [7:0] o_chk_in,
    input  logic       i_chk_result,
    output logic       o_done_valid,
    output logic       o_done_id,
    output logic       o_done_ok,
    output logic       o_done_ovf
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, SAMPLE} state_t;

    state_t          r_state;
    logic            r_grant, r_last_id, r_ovf;
    logic [CW-1:0]   r_cnt;
    logic            r_rdy0, r_rdy1, r_chk_rst, r_chk_en;
    logic [7:0]      r_chk_in;
    logic            r_done_valid, r_done_id, r_done_ok, r_done_ovf;
    logic            w_hs, w_last, w_end, w_gnt;
    logic [7:0]      w_data;

    assign w_hs   = r_grant ? (i_req1_valid & r_rdy1) : (i_req0_valid & r_rdy0);
    assign w_data = r_grant ? i_req1_data : i_req0_data;
    assign w_last = r_grant ? i_req1_last : i_req0_last;
    assign w_end  = w_last | (r_cnt == CW'(MAX_LEN - 1));
    // Contention goes to the requester that did not own the previous message.
    assign w_gnt  = (i_req0_valid & i_req1_valid) ? ~r_last_id : i_req1_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_id    <= 1'b1;
            r_ovf        <= 1'b0;
            r_cnt        <= '0;
            r_rdy0       <= 1'b0;
            r_rdy1       <= 1'b0;
            r_chk_rst    <= 1'b1;
            r_chk_en     <= 1'b0;
            r_chk_in     <= 8'h00;
            r_done_valid <= 1'b0;
            r_done_id    <= 1'b0;
            r_done_ok    <= 1'b0;
            r_done_ovf   <= 1'b0;
        end else begin
            r_chk_rst    <= 1'b0;
            r_chk_en     <= 1'b0;
            r_done_valid <= 1'b0;
            case (r_state)
                IDLE: if (i_req0_valid | i_req1_valid) begin
                    r_grant   <= w_gnt;
                    r_chk_rst <= 1'b1;
                    r_state   <= CLEAR;
                end
                CLEAR: begin
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                    r_rdy0  <= ~r_grant;
                    r_rdy1  <= r_grant;
                    r_state <= STREAM;
                end
                STREAM: if (w_hs) begin
                    r_chk_in <= w_data;
                    r_chk_en <= 1'b1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_end) begin
                        r_rdy0  <= 1'b0;
                        r_rdy1  <= 1'b0;
                        r_ovf   <= ~w_last;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: r_state <= SAMPLE;
                SAMPLE: begin
                    r_done_valid <= 1'b1;
                    r_done_id    <= r_grant;
                    r_done_ok    <= i_chk_result & ~r_ovf;
                    r_done_ovf   <= r_ovf;
                    r_last_id    <= r_grant;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req0_ready = r_rdy0;
    assign o_req1_ready = r_rdy1;
    assign o_chk_rst    = r_chk_rst;
    assign o_chk_en     = r_chk_en;
    assign o_chk_in     = r_chk_in;
    assign o_done_valid = r_done_valid;
    assign o_done_id    = r_done_id;
    assign o_done_ok    = r_done_ok;
    assign o_done_ovf   = r_done_ovf;
endmodule

// File: tb/tb_check_session_arbiter.sv
// tb_check_session_arbiter: two arbiters (MAX_LEN 64 and 4) each feeding a clocked
// nesting-checker stand-in, checked against a message-level scoreboard.
module tb_check_session_arbiter;
    logic clk = 0, rst = 0, abort = 0;
    always #5 clk = ~clk;

    logic       vld[2][2], lst[2][2], rdy[2][2];
    logic [7:0] dat[2][2];
    logic       crst[2], cen[2], cres[2], dv[2], did[2], dok[2], dovf[2];
    logic [7:0] cin[2];

    int n_vec = 0, n_bad = 0, cyc = 0;
    int ml[2] = '{64, 4};

    check_session_arbiter #(.MAX_LEN(64)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0_valid(vld[0][0]), .i_req0_data(dat[0][0]), .i_req0_last(lst[0][0]), .o_req0_ready(rdy[0][0]),
        .i_req1_valid(vld[0][1]), .i_req1_data(dat[0][1]), .i_req1_last(lst[0][1]), .o_req1_ready(rdy[0][1]),
        .o_chk_rst(crst[0]), .o_chk_en(cen[0]), .o_chk_in(cin[0]), .i_chk_result(cres[0]),
        .o_done_valid(dv[0]), .o_done_id(did[0]), .o_done_ok(dok[0]), .o_done_ovf(dovf[0]));

    check_session_arbiter #(.MAX_LEN(4)) u_small (
        .i_clk(clk), .i_reset(rst),
        .i_req0_valid(vld[1][0]), .i_req0_data(dat[1][0]), .i_req0_last(lst[1][0]), .o_req0_ready(rdy[1][0]),
        .i_req1_valid(vld[1][1]), .i_req1_data(dat[1][1]), .i_req1_last(lst[1][1]), .o_req1_ready(rdy[1][1]),
        .o_chk_rst(crst[1]), .o_chk_en(cen[1]), .o_chk_in(cin[1]), .i_chk_result(cres[1]),
        .o_done_valid(dv[1]), .o_done_id(did[1]), .o_done_ok(dok[1]), .o_done_ovf(dovf[1]));

    function automatic logic [7:0] lc(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction

    // Clocked checker stand-in: case-insensitive begin/end nesting, shifts only on enable.
    logic [39:0] sh[2];
    int          dep[2];
    logic        err[2];
    always @(posedge clk)
        for (int d = 0; d < 2; d++) begin
            if (crst[d]) begin
                sh[d] <= '0; dep[d] <= 0; err[d] <= 1'b0;
            end else if (cen[d]) begin
                sh[d] <= {sh[d][31:0], lc(cin[d])};
                if ({sh[d][31:0], lc(cin[d])} == "begin") dep[d] <= dep[d] + 1;
                else if ({sh[d][15:0], lc(cin[d])} == "end") begin
                    if (dep[d] == 0) err[d] <= 1'b1;
                    else dep[d] <= dep[d] - 1;
                end
            end
        end
    assign cres[0] = (dep[0] == 0) && !err[0];
    assign cres[1] = (dep[1] == 0) && !err[1];

    // Reference verdict over a whole message.
    function automatic bit balanced(input logic [7:0] q[$]);
        int d = 0;
        bit e = 0;
        logic [39:0] w;
        for (int i = 0; i < q.size(); i++) begin
            w = '0;
            for (int j = 0; j < 5 && j <= i; j++) w[8*j +: 8] = lc(q[i-j]);
            if (w == "begin") d++;
            else if (w[23:0] == "end") begin
                if (d == 0) e = 1;
                else d--;
            end
        end
        return !e && d == 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [2:0] res; int due; } exp_t;
    exp_t       sb[2][$];
    logic [7:0] cur[2][$];
    logic [2:0] dlog[2][$];
    int         owner[2] = '{-1, -1}, ndone[2] = '{0, 0}, en_cnt[2] = '{0, 0}, rst_pulses[2] = '{0, 0};
    bit         phs[2], pdv[2], pcrst[2];
    logic [7:0] pbyte[2];

    initial begin
        exp_t e;
        bit   ov;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    cur[d].delete(); sb[d].delete();
                    owner[d] = -1; phs[d] = 0; pdv[d] = 0; pcrst[d] = 0;
                    continue;
                end
                if (phs[d] || cen[d]) check("chk_en", cen[d], phs[d]);
                if (phs[d]) check("chk_in", cin[d], pbyte[d]);
                if (cen[d]) en_cnt[d]++;
                if (rdy[d][0] || rdy[d][1]) check("ready_excl", rdy[d][0] & rdy[d][1], 0);
                if (crst[d]) check("chk_rst_pulse", pcrst[d], 0);
                if (crst[d] && !pcrst[d]) rst_pulses[d]++;
                if (dv[d]) begin
                    check("done_repeat", pdv[d], 0);
                    check("done_expected", sb[d].size() != 0, 1);
                    if (sb[d].size() != 0) begin
                        e = sb[d].pop_front();
                        check("done_fields", {did[d], dok[d], dovf[d]}, e.res);
                        check("done_latency", cyc, e.due);
                    end
                    ndone[d]++;
                    dlog[d].push_back({did[d], dok[d], dovf[d]});
                end else if (sb[d].size() != 0 && sb[d][0].due < cyc) begin
                    check("done_missing", dv[d], 1);
                    void'(sb[d].pop_front());
                end
                phs[d] = 0;
                for (int p = 0; p < 2; p++)
                    if (vld[d][p] && rdy[d][p]) begin
                        if (owner[d] >= 0) check("owner", p, owner[d]);
                        owner[d] = p;
                        cur[d].push_back(dat[d][p]);
                        phs[d] = 1;
                        pbyte[d] = dat[d][p];
                        if (lst[d][p] || cur[d].size() == ml[d]) begin
                            ov = !lst[d][p];
                            e.res = {p[0], balanced(cur[d]) && !ov, ov};
                            e.due = cyc + 3;
                            sb[d].push_back(e);
                            cur[d].delete();
                            owner[d] = -1;
                        end
                    end
                pdv[d] = dv[d];
                pcrst[d] = crst[d];
            end
        end
    end

    task automatic send(input int d, input int p, input string s, input int gm);
        int t;
        @(posedge clk); #1;
        for (int i = 0; i < s.len(); i++) begin
            if ((gm == 1 && (i == 3 || i == 6)) || (gm == 2 && $urandom_range(3) == 0)) begin
                vld[d][p] = 0;
                repeat (gm == 1 ? 3 : $urandom_range(2, 1)) @(posedge clk);
                #1;
            end
            vld[d][p] = 1; dat[d][p] = s[i]; lst[d][p] = (i == s.len() - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!rdy[d][p] && !abort && t < 300);
            if (abort) break;
            if (!rdy[d][p]) begin
                check("ready_timeout", rdy[d][p], 1);
                break;
            end
            @(posedge clk); #1;
        end
        vld[d][p] = 0; lst[d][p] = 0;
    endtask

    task automatic wait_done(input int d, input int n, input string name);
        int t = 0;
        while (ndone[d] < n && t < 200) begin @(negedge clk); t++; end
        check(name, ndone[d] >= n, 1);
    endtask

    task automatic chk_reset(input int d, input string name);
        check(name, {crst[d], rdy[d][0], rdy[d][1], cen[d], cin[d], dv[d], did[d], dok[d], dovf[d]}, 16'h8000);
    endtask

    function automatic string rmsg();
        string toks[5] = '{"begin", "end", " ", "x", "BEGIN"};
        string s = "";
        int n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) s = {s, toks[$urandom_range(4)]};
        return s;
    endfunction

    typedef struct { int port; string msg; int gm; logic [2:0] res; } vec_t;
    vec_t tbl[8];
    int   exp_ids[7] = '{0, 1, 0, 1, 0, 1, 0};

    initial begin
        int n0, e0, t;
        tbl[0] = '{0, "begin end", 0, 3'b010};
        tbl[1] = '{1, "end begin", 0, 3'b100};
        tbl[2] = '{0, "BEGIN END", 1, 3'b010};
        tbl[3] = '{1, "begin begin end end", 0, 3'b110};
        tbl[4] = '{0, "begin", 2, 3'b000};
        tbl[5] = '{1, "x", 0, 3'b110};
        tbl[6] = '{0, "end", 0, 3'b000};
        tbl[7] = '{1, "begin end end", 2, 3'b100};
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin vld[d][p] = 0; lst[d][p] = 0; dat[d][p] = 0; end

        #2 rst = 1;
        #1 chk_reset(0, "reset_vals0"); chk_reset(1, "reset_vals1");
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        check("chk_rst_release0", crst[0], 0);
        check("chk_rst_release1", crst[1], 0);

        foreach (tbl[i]) begin
            n0 = ndone[0]; e0 = en_cnt[0];
            send(0, tbl[i].port, tbl[i].msg, tbl[i].gm);
            wait_done(0, n0 + 1, "vec_done");
            if (ndone[0] > n0) check({"vec ", tbl[i].msg}, dlog[0][dlog[0].size()-1], tbl[i].res);
            check("vec_en_cnt", en_cnt[0] - e0, tbl[i].msg.len());
        end

        dlog[0].delete(); n0 = ndone[0];
        repeat (2) fork send(0, 0, "abc", 0); send(0, 1, "xyz", 0); join
        send(0, 0, "q", 0);
        fork send(0, 0, "abc", 0); send(0, 1, "xyz", 0); join
        wait_done(0, n0 + 7, "arb_done");
        check("arb_count", dlog[0].size(), 7);
        foreach (exp_ids[i]) if (dlog[0].size() > i) check("arb_order", dlog[0][i][2], exp_ids[i]);

        n0 = ndone[1]; e0 = rst_pulses[1];
        send(1, 0, "beginx", 0);
        wait_done(1, n0 + 2, "ovf_done");
        if (ndone[1] >= n0 + 2) begin
            check("ovf_first", dlog[1][n0], 3'b001);
            check("ovf_second", dlog[1][n0+1], 3'b010);
        end
        check("ovf_clears", rst_pulses[1] - e0, 2);

        for (int it = 0; it < 30; it++) begin
            int d = $urandom_range(1);
            case ($urandom_range(2))
                0: send(d, 0, rmsg(), 2);
                1: send(d, 1, rmsg(), 2);
                default: fork send(d, 0, rmsg(), 2); send(d, 1, rmsg(), 2); join
            endcase
            t = 0;
            while (sb[d].size() != 0 && t < 100) begin @(negedge clk); t++; end
            check("rand_drain", sb[d].size(), 0);
        end

        send(0, 0, "q", 0);
        wait_done(0, ndone[0] + 1, "pre_reset_done");
        n0 = ndone[0];
        fork send(0, 0, "begin end", 0); join_none
        t = 0;
        while (cur[0].size() < 3 && t < 100) begin @(negedge clk); t++; end
        check("mid_reset_reach", cur[0].size(), 3);
        @(posedge clk); #2;
        rst = 1; abort = 1;
        #1 chk_reset(0, "mid_reset_vals0"); chk_reset(1, "mid_reset_vals1");
        repeat (3) @(posedge clk);
        abort = 0;
        #1 rst = 0;
        repeat (6) @(posedge clk);
        check("mid_reset_no_done", ndone[0], n0);
        dlog[0].delete();
        fork send(0, 0, "abc", 0); send(0, 1, "xyz", 0); join
        wait_done(0, n0 + 2, "post_reset_done");
        if (dlog[0].size() >= 2) check("post_reset_order", {dlog[0][0][2], dlog[0][1][2]}, 2'b01);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
